// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the four requesters, the arbiter and the UART TX sequencer.
// master = arbiter side, slave = requesters plus sequencer side.
interface uart_tx_arb_if #(
   parameter int DATA_W = 8
);
   logic [3:0]          req;
   logic [4*DATA_W-1:0] req_data;
   logic                tx_busy;
   logic                tx_en;
   logic [DATA_W-1:0]   tx_data;
   logic [3:0]          grant;
   logic [3:0]          ack;
   logic [3:0]          done;
   logic                err;

   modport master (
      input  req, req_data, tx_busy,
      output tx_en, tx_data, grant, ack, done, err
   );

   modport slave (
      output req, req_data, tx_busy,
      input  tx_en, tx_data, grant, ack, done, err
   );
endinterface

// File: rtl/uart_tx_arb.sv
// Four-way arbiter in front of a UART TX sequencer: picks one requester, launches its byte, tracks busy.
// Build option UART_TX_ARB_RR_EN selects round-robin; without it selection is fixed priority (index 0 highest).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no owner, grant = 0; sample req and latch the winner
// LAUNCH    | single cycle: tx_en and ack[winner] high
// WAIT_BUSY | wait for tx_busy to rise; BUSY_TO cycles without it -> err
// WAIT_DONE | sequencer busy; its fall ends the transaction with done
module uart_tx_arb #(
   parameter int DATA_W  = 8,
   parameter int BUSY_TO = 16
) (
   input logic           clk_50M,
   input logic           rst_n,
   uart_tx_arb_if.master bus
);

   localparam int               CNT_W    = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TO - 1);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  to_cnt;
   logic [1:0]        win_idx;
   logic              win_vld;
   logic [3:0]        win_oh;
   logic [DATA_W-1:0] win_data;

`ifdef UART_TX_ARB_RR_EN
   logic [1:0] rr_ptr;
   logic [1:0] cand;

   // Walk offsets 4..1 so the closest requester after the last winner is written last and wins.
   always_comb begin
      win_idx = 2'd0;
      win_vld = 1'b0;
      cand    = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         cand = rr_ptr + 2'(k);
         if (bus.req[cand]) begin
            win_idx = cand;
            win_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         rr_ptr <= 2'd3;
      end else if (state == IDLE && win_vld) begin
         rr_ptr <= win_idx;
      end
   end
`else
   always_comb begin
      win_idx = 2'd0;
      win_vld = |bus.req;
      for (int k = 3; k >= 0; k--) begin
         if (bus.req[k]) begin
            win_idx = 2'(k);
         end
      end
   end
`endif

   always_comb begin
      win_oh   = 4'b0001 << win_idx;
      win_data = bus.req_data[win_idx*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state       <= IDLE;
         to_cnt      <= '0;
         bus.tx_en   <= 1'b0;
         bus.tx_data <= '0;
         bus.grant   <= '0;
         bus.ack     <= '0;
         bus.done    <= '0;
         bus.err     <= 1'b0;
      end else begin
         bus.tx_en <= 1'b0;
         bus.ack   <= '0;
         bus.done  <= '0;
         bus.err   <= 1'b0;

         unique case (state)
            IDLE: begin
               if (win_vld) begin
                  bus.tx_data <= win_data;
                  bus.grant   <= win_oh;
                  bus.tx_en   <= 1'b1;
                  bus.ack     <= win_oh;
                  state       <= LAUNCH;
               end
            end

            LAUNCH: begin
               to_cnt <= '0;
               state  <= WAIT_BUSY;
            end

            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  to_cnt <= '0;
                  state  <= WAIT_DONE;
               end else if (to_cnt == CNT_LAST) begin
                  // Sequencer never accepted the launch: abandon without done.
                  bus.err   <= 1'b1;
                  bus.grant <= '0;
                  to_cnt    <= '0;
                  state     <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  bus.done  <= bus.grant;
                  bus.grant <= '0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: vector table plus hand sequences, scoreboard queues of expected grants.
// Expectations for multi-request cases follow UART_TX_ARB_RR_EN when it is defined.
module tb_uart_tx_arb;

   localparam int DATA_W   = 8;
   localparam int BUSY_LEN = 10;
   localparam int LAT_DONE = 12;
   localparam int LAT_TO   = 17;

   logic clk_50M = 1'b0;
   logic rst_n   = 1'b0;

   uart_tx_arb_if #(.DATA_W(DATA_W)) bus ();

   uart_tx_arb #(.DATA_W(DATA_W), .BUSY_TO(16)) dut (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #10 clk_50M = ~clk_50M;

   typedef struct {
      logic [3:0]  g;
      logic [7:0]  d;
      logic        to;
      int          lat;
      int          acyc;
   } exp_t;

   typedef struct {
      logic [3:0]  r;
      logic [31:0] rd;
      logic [3:0]  g;
      logic [7:0]  d;
      logic        to;
   } vec_t;

   exp_t exp_q[$];
   exp_t pend_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ack_cnt = 0;
   int cmp_cnt = 0;
   int last_ack_cyc = 0;
   int last_cmp_cyc = 0;
   bit resp_on = 1'b1;

   always @(posedge clk_50M) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [3:0] g, input logic [7:0] d, input logic to, input int lat);
      exp_t e;
      e.g = g; e.d = d; e.to = to; e.lat = lat; e.acyc = 0;
      exp_q.push_back(e);
   endtask

   task automatic wait_evt(input bit is_cmp, input int target, input int budget, input string nm);
      int n = 0;
      while ((is_cmp ? cmp_cnt : ack_cnt) < target && n < budget) begin
         @(negedge clk_50M); #1;
         n++;
      end
      if ((is_cmp ? cmp_cnt : ack_cnt) < target) chk(nm, is_cmp ? cmp_cnt : ack_cnt, target);
   endtask

   task automatic wait_busy_high(input int budget);
      int n = 0;
      while (!bus.tx_busy && n < budget) begin
         @(negedge clk_50M); #1;
         n++;
      end
      if (!bus.tx_busy) chk("busy_wait_timeout", bus.tx_busy, 1);
   endtask

   // Sequencer model: busy rises one cycle after tx_en and stays high BUSY_LEN cycles.
   initial begin
      int bcnt;
      bit pend;
      bcnt = 0;
      pend = 1'b0;
      bus.tx_busy = 1'b0;
      forever begin
         @(posedge clk_50M); #1;
         if (!rst_n) begin
            bus.tx_busy = 1'b0; bcnt = 0; pend = 1'b0;
         end else if (pend) begin
            bus.tx_busy = 1'b1; pend = 1'b0; bcnt = BUSY_LEN;
         end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) bus.tx_busy = 1'b0;
         end else if (bus.tx_en && resp_on) begin
            pend = 1'b1;
         end
      end
   end

   // Scoreboard: launches pop exp_q, completions pop pend_q.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_50M);
         if (bus.tx_en || (|bus.ack)) begin
            chk("txen_with_ack", {31'd0, bus.tx_en}, {31'd0, |bus.ack});
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", {28'd0, bus.ack}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("ack", {28'd0, bus.ack}, {28'd0, e.g});
               chk("grant", {28'd0, bus.grant}, {28'd0, e.g});
               chk("tx_data", {24'd0, bus.tx_data}, {24'd0, e.d});
               e.acyc = cyc;
               pend_q.push_back(e);
               ack_cnt++;
               last_ack_cyc = cyc;
            end
         end
         if ((|bus.done) || bus.err) begin
            if (pend_q.size() == 0) begin
               chk("unexpected_end", {27'd0, bus.err, bus.done}, 32'd0);
            end else begin
               e = pend_q.pop_front();
               chk("done", {28'd0, bus.done}, e.to ? 32'd0 : {28'd0, e.g});
               chk("err", {31'd0, bus.err}, {31'd0, e.to});
               chk("grant_clear", {28'd0, bus.grant}, 32'd0);
               chk("end_latency", cyc - e.acyc, e.lat);
               cmp_cnt++;
               last_cmp_cyc = cyc;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tx_en"},   {31'd0, bus.tx_en}, 32'd0);
      chk({tag, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
      chk({tag, "_grant"},   {28'd0, bus.grant}, 32'd0);
      chk({tag, "_ack"},     {28'd0, bus.ack}, 32'd0);
      chk({tag, "_done"},    {28'd0, bus.done}, 32'd0);
      chk({tag, "_err"},     {31'd0, bus.err}, 32'd0);
   endtask

   vec_t vecs[6];

   initial begin
      int base_a;
      int base_c;
      int rel_cyc;
      int prev_cmp;

      vecs[0] = '{r: 4'b0001, rd: 32'h1122_3355, g: 4'b0001, d: 8'h55, to: 1'b0};
      vecs[1] = '{r: 4'b1000, rd: 32'hA3C4_B201, g: 4'b1000, d: 8'hA3, to: 1'b0};
      vecs[2] = '{r: 4'b0010, rd: 32'h0000_B200, g: 4'b0010, d: 8'hB2, to: 1'b0};
      vecs[3] = '{r: 4'b0100, rd: 32'h00C4_0000, g: 4'b0100, d: 8'hC4, to: 1'b1};
      vecs[4] = '{r: 4'b0110, rd: 32'h0066_6100, g: 4'b0010, d: 8'h61, to: 1'b0};
`ifdef UART_TX_ARB_RR_EN
      vecs[5] = '{r: 4'b1001, rd: 32'hD000_000D, g: 4'b1000, d: 8'hD0, to: 1'b0};
`else
      vecs[5] = '{r: 4'b1001, rd: 32'hD000_000D, g: 4'b0001, d: 8'h0D, to: 1'b0};
`endif

      bus.req      = 4'b0000;
      bus.req_data = '0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk_50M);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Contention right after reset (round-robin pointer starts at 3).
      base_a = ack_cnt;
      base_c = cmp_cnt;
      bus.req_data = 32'h4433_2211;
`ifdef UART_TX_ARB_RR_EN
      push_exp(4'b0001, 8'h11, 1'b0, LAT_DONE);
      push_exp(4'b0010, 8'h22, 1'b0, LAT_DONE);
      push_exp(4'b0100, 8'h33, 1'b0, LAT_DONE);
      push_exp(4'b1000, 8'h44, 1'b0, LAT_DONE);
      bus.req = 4'b1111;
      wait_evt(1'b0, base_a + 4, 200, "contention_ack_timeout");
      bus.req = 4'b0000;
`else
      push_exp(4'b0010, 8'h22, 1'b0, LAT_DONE);
      push_exp(4'b0010, 8'h22, 1'b0, LAT_DONE);
      push_exp(4'b0010, 8'h22, 1'b0, LAT_DONE);
      push_exp(4'b1000, 8'h44, 1'b0, LAT_DONE);
      bus.req = 4'b1010;
      wait_evt(1'b0, base_a + 3, 200, "contention_ack_timeout");
      bus.req = 4'b1000;
      wait_evt(1'b0, base_a + 4, 100, "contention_ack_timeout");
      bus.req = 4'b0000;
`endif
      wait_evt(1'b1, base_c + 4, 100, "contention_end_timeout");

      // Vector table: one transaction per row.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_50M); #1;
         base_a = ack_cnt;
         base_c = cmp_cnt;
         resp_on = !vecs[i].to;
         bus.req_data = vecs[i].rd;
         push_exp(vecs[i].g, vecs[i].d, vecs[i].to, vecs[i].to ? LAT_TO : LAT_DONE);
         bus.req = vecs[i].r;
         wait_evt(1'b0, base_a + 1, 50, "vec_ack_timeout");
         bus.req = 4'b0000;
         wait_evt(1'b1, base_c + 1, 60, "vec_end_timeout");
      end
      resp_on = 1'b1;

      // Late request: req[2] rises during WAIT_DONE and must wait for IDLE.
      @(negedge clk_50M); #1;
      base_a = ack_cnt;
      base_c = cmp_cnt;
      bus.req_data = 32'h009C_003E;
      push_exp(4'b0001, 8'h3E, 1'b0, LAT_DONE);
      push_exp(4'b0100, 8'h9C, 1'b0, LAT_DONE);
      bus.req = 4'b0001;
      wait_evt(1'b0, base_a + 1, 50, "late_first_ack_timeout");
      bus.req = 4'b0000;
      wait_busy_high(20);
      @(negedge clk_50M); #1;
      bus.req = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_50M); #1;
         chk("late_grant_hold", {28'd0, bus.grant}, 32'd1);
         chk("late_no_ack", {28'd0, bus.ack}, 32'd0);
      end
      wait_evt(1'b0, base_a + 2, 50, "late_second_ack_timeout");
      prev_cmp = last_cmp_cyc;
      chk("late_spacing", last_ack_cyc - prev_cmp, 1);
      bus.req = 4'b0000;
      wait_evt(1'b1, base_c + 2, 60, "late_end_timeout");

      // Reset while in WAIT_DONE.
      @(negedge clk_50M); #1;
      base_a = ack_cnt;
      bus.req_data = 32'h0077_0012;
      push_exp(4'b0001, 8'h12, 1'b0, LAT_DONE);
      bus.req = 4'b0001;
      wait_evt(1'b0, base_a + 1, 50, "rst_first_ack_timeout");
      bus.req = 4'b0000;
      wait_busy_high(20);
      @(negedge clk_50M); #1;
      @(negedge clk_50M);
      rst_n   = 1'b0;
      bus.req = 4'b0100;
      @(negedge clk_50M); #1;
      chk_all_zero("midrst");
      pend_q.delete();
      base_a = ack_cnt;
      base_c = cmp_cnt;
      push_exp(4'b0100, 8'h77, 1'b0, LAT_DONE);
      rst_n   = 1'b1;
      rel_cyc = cyc;
      wait_evt(1'b0, base_a + 1, 20, "rst_regrant_timeout");
      chk("rst_regrant_latency", last_ack_cyc - rel_cyc, 1);
      bus.req = 4'b0000;
      wait_evt(1'b1, base_c + 1, 60, "rst_end_timeout");

      repeat (5) @(negedge clk_50M);
      #1;
      chk("exp_q_drained", exp_q.size(), 0);
      chk("pend_q_drained", pend_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
